// File: rtl/inst_cache_pkg.sv
// Shared definitions for the instruction cache: state codes, geometry defaults
// and the address/data word types.
package inst_cache_pkg;

    localparam int IC_INDEX_BITS   = 6;
    localparam int IC_ABORT_CYCLES = 7;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    typedef enum logic [1:0] {
        IC_IDLE  = 2'd0,
        IC_MISS  = 2'd1,
        IC_ABORT = 2'd2
    } ic_state_e;

endpackage

// File: rtl/inst_cache_array.sv
// Direct-mapped tag/data store: combinational lookup, synchronous fill,
// valid bits cleared asynchronously by reset.
module inst_cache_array
    import inst_cache_pkg::*;
#(
    parameter int INDEX_BITS = IC_INDEX_BITS,
    localparam int TAG_BITS  = 32 - INDEX_BITS - 2,
    localparam int LINES     = 1 << INDEX_BITS
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [INDEX_BITS-1:0] rd_idx,
    input  logic [TAG_BITS-1:0]   rd_tag,
    output logic                  rd_hit,
    output data_t                 rd_word,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  data_t                 wr_data
);

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    data_t               data_q [LINES];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are never consulted while valid is low.
    always_ff @(posedge clk_in) begin
        if (we) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_word = data_q[rd_idx];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache between fetch and the memory controller,
// with pipeline-clear abort that drains a stale controller response.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IC_IDLE  | serve hits, launch a controller fetch on a miss
//   IC_MISS  | request held to the controller until its word returns
//   IC_ABORT | fetch cancelled by clear; absorb a late response or time out
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int INDEX_BITS   = IC_INDEX_BITS,
    parameter int ABORT_CYCLES = IC_ABORT_CYCLES
) (
    input  logic  clk_in,
    input  logic  rst_in,
    input  logic  rdy_in,
    input  logic  clr_in,
    input  logic  if_to_ic_valid,
    input  addr_t if_to_ic_pc,
    output logic  ic_to_if_ready,
    output data_t ic_to_if_inst,
    output logic  ic_to_mc_ready,
    output addr_t ic_to_mc_PC,
    input  logic  mc_to_ic_ready,
    input  data_t mc_to_ic_inst
);

    localparam int TAG_BITS = 32 - INDEX_BITS - 2;
    localparam int CNT_W    = (ABORT_CYCLES > 2) ? $clog2(ABORT_CYCLES) : 1;

    ic_state_e  state, state_nxt;
    logic [CNT_W-1:0] abort_cnt, abort_cnt_nxt;
    addr_t      miss_pc, miss_pc_nxt;
    logic       if_ready_nxt, mc_ready_nxt;
    data_t      if_inst_nxt;
    logic       fill_we;
    logic       rd_hit;
    data_t      rd_word;
    logic       lookup;
    logic       cnt_done;

    inst_cache_array #(
        .INDEX_BITS (INDEX_BITS)
    ) u_array (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .rd_idx  (if_to_ic_pc[INDEX_BITS+1:2]),
        .rd_tag  (if_to_ic_pc[31:INDEX_BITS+2]),
        .rd_hit  (rd_hit),
        .rd_word (rd_word),
        .we      (fill_we && rdy_in),
        .wr_idx  (miss_pc[INDEX_BITS+1:2]),
        .wr_tag  (miss_pc[31:INDEX_BITS+2]),
        .wr_data (mc_to_ic_inst)
    );

    // A response this cycle forces a bubble so a PC advanced at that edge is not re-served.
    assign lookup   = if_to_ic_valid && !ic_to_if_ready && !clr_in;
    assign cnt_done = (abort_cnt == CNT_W'(ABORT_CYCLES - 1));

    assign ic_to_mc_PC = miss_pc;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state          <= IC_IDLE;
            abort_cnt      <= '0;
            miss_pc        <= '0;
            ic_to_if_ready <= 1'b0;
            ic_to_if_inst  <= '0;
            ic_to_mc_ready <= 1'b0;
        end else if (rdy_in) begin
            state          <= state_nxt;
            abort_cnt      <= abort_cnt_nxt;
            miss_pc        <= miss_pc_nxt;
            ic_to_if_ready <= if_ready_nxt;
            ic_to_if_inst  <= if_inst_nxt;
            ic_to_mc_ready <= mc_ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IC_IDLE: begin
                if (lookup && !rd_hit) state_nxt = IC_MISS;
            end
            IC_MISS: begin
                if (mc_to_ic_ready)  state_nxt = IC_IDLE;
                else if (clr_in)     state_nxt = IC_ABORT;
            end
            IC_ABORT: begin
                if (mc_to_ic_ready)  state_nxt = IC_IDLE;
                else if (clr_in)     state_nxt = IC_ABORT;
                else if (cnt_done)   state_nxt = IC_IDLE;
            end
            default: state_nxt = IC_IDLE;
        endcase
    end

    always_comb begin
        if_ready_nxt  = 1'b0;
        if_inst_nxt   = ic_to_if_inst;
        mc_ready_nxt  = ic_to_mc_ready;
        miss_pc_nxt   = miss_pc;
        abort_cnt_nxt = abort_cnt;
        fill_we       = 1'b0;
        case (state)
            IC_IDLE: begin
                mc_ready_nxt = 1'b0;
                if (lookup) begin
                    if (rd_hit) begin
                        if_ready_nxt = 1'b1;
                        if_inst_nxt  = rd_word;
                    end else begin
                        miss_pc_nxt  = if_to_ic_pc;
                        mc_ready_nxt = 1'b1;
                    end
                end
            end
            IC_MISS: begin
                if (mc_to_ic_ready) begin
                    fill_we      = 1'b1;
                    mc_ready_nxt = 1'b0;
                    if (!clr_in) begin
                        if_ready_nxt = 1'b1;
                        if_inst_nxt  = mc_to_ic_inst;
                    end
                end else if (clr_in) begin
                    mc_ready_nxt  = 1'b0;
                    abort_cnt_nxt = '0;
                end
            end
            IC_ABORT: begin
                mc_ready_nxt = 1'b0;
                // A late word still belongs to miss_pc, so keep it.
                if (mc_to_ic_ready) begin
                    fill_we = 1'b1;
                end else if (clr_in) begin
                    abort_cnt_nxt = '0;
                end else if (!cnt_done) begin
                    abort_cnt_nxt = abort_cnt + 1'b1;
                end
            end
            default: begin
                mc_ready_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_inst_cache.sv
// Scoreboard bench for inst_cache: directed scenarios plus randomized fetches
// checked against a line-level cache model and a latency-programmable memory model.
module tb_inst_cache;
    import inst_cache_pkg::*;

    localparam int LINES = 64;
    localparam int ABORT = 7;

    logic  clk_in = 1'b0;
    logic  rst_in = 1'b0;
    logic  rdy_in = 1'b1;
    logic  clr_in = 1'b0;
    logic  if_to_ic_valid = 1'b0;
    addr_t if_to_ic_pc = '0;
    logic  ic_to_if_ready;
    data_t ic_to_if_inst;
    logic  ic_to_mc_ready;
    addr_t ic_to_mc_PC;
    logic  mc_to_ic_ready;
    data_t mc_to_ic_inst;

    inst_cache #(
        .INDEX_BITS   (6),
        .ABORT_CYCLES (ABORT)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .clr_in         (clr_in),
        .if_to_ic_valid (if_to_ic_valid),
        .if_to_ic_pc    (if_to_ic_pc),
        .ic_to_if_ready (ic_to_if_ready),
        .ic_to_if_inst  (ic_to_if_inst),
        .ic_to_mc_ready (ic_to_mc_ready),
        .ic_to_mc_PC    (ic_to_mc_PC),
        .mc_to_ic_ready (mc_to_ic_ready),
        .mc_to_ic_inst  (mc_to_ic_inst)
    );

    always #5 clk_in = ~clk_in;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_inst_q[$];
    logic [31:0] exp_mc_q[$];
    bit          m_valid[LINES];
    logic [31:0] m_line[LINES];
    logic [31:0] mem_ovr[logic [31:0]];
    int          mc_lat = 6;
    bit          mc_mute = 1'b0;
    bit          just_served = 1'b0;
    bit          mc_prev = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one word per line, line chosen by word address modulo line count.
    function automatic int midx(input logic [31:0] pc);
        return int'((pc >> 2) % LINES);
    endfunction

    function automatic bit mhit(input logic [31:0] pc);
        return m_valid[midx(pc)] && (m_line[midx(pc)] == (pc & ~32'h3));
    endfunction

    function automatic void mfill(input logic [31:0] pc);
        m_valid[midx(pc)] = 1'b1;
        m_line[midx(pc)]  = pc & ~32'h3;
    endfunction

    function automatic void mclear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        logic [31:0] a;
        a = pc & ~32'h3;
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return a * 32'h9E3779B1 + 32'h01234567;
    endfunction

    // Memory controller: latches a request, answers mc_lat cycles later with a one-cycle pulse.
    initial begin
        mc_to_ic_ready = 1'b0;
        mc_to_ic_inst  = '0;
        forever begin
            logic [31:0] a;
            int          l;
            @(negedge clk_in);
            if (rst_in && rdy_in && ic_to_mc_ready && !mc_mute) begin
                a = ic_to_mc_PC;
                l = mc_lat;
                repeat (l) @(negedge clk_in);
                mc_to_ic_inst  = mem_word(a);
                mc_to_ic_ready = 1'b1;
                @(negedge clk_in);
                mc_to_ic_ready = 1'b0;
                mc_to_ic_inst  = $urandom();
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT responds or raises a new controller request.
    initial begin
        forever begin
            @(negedge clk_in);
            if (rst_in && rdy_in) begin
                if (ic_to_if_ready) begin
                    if (exp_inst_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_response: got %0h, expected none", ic_to_if_inst);
                    end else begin
                        check32("inst", ic_to_if_inst, exp_inst_q.pop_front());
                    end
                    check32("mc_ready_low_on_resp", 32'(ic_to_mc_ready), 32'd0);
                end
                if (ic_to_mc_ready && !mc_prev) begin
                    if (exp_mc_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_mc_request: got %0h, expected none", ic_to_mc_PC);
                    end else begin
                        check32("mc_pc", ic_to_mc_PC, exp_mc_q.pop_front());
                    end
                end
            end
            mc_prev = ic_to_mc_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic settle();
        if (just_served) begin
            if_to_ic_valid = 1'b0;
            @(negedge clk_in);
            just_served = 1'b0;
        end
    endtask

    task automatic fetch(input logic [31:0] pc, input bit b2b, input bit clr_first);
        int extra, k, exp_k;
        bit hit;
        extra = 0;
        if (just_served && b2b) extra = 1;
        else if (just_served) begin
            if_to_ic_valid = 1'b0;
            @(negedge clk_in);
        end
        just_served = 1'b0;
        hit = mhit(pc);
        if (clr_first && extra == 0) begin
            clr_in = 1'b1;
            extra  = 1;
        end
        exp_k = hit ? 1 + extra : mc_lat + 2 + extra;
        if (!hit) begin
            exp_mc_q.push_back(pc);
            mfill(pc);
        end
        exp_inst_q.push_back(mem_word(pc));
        if_to_ic_valid = 1'b1;
        if_to_ic_pc    = pc;
        k = 0;
        do begin
            @(negedge clk_in);
            clr_in = 1'b0;
            k++;
        end while (!ic_to_if_ready && k < 100);
        check32("fetch_latency", k, exp_k);
        just_served = ic_to_if_ready;
        if (!just_served) if_to_ic_valid = 1'b0;
    endtask

    // Miss on pc, then a clear d cycles after the request is presented; the controller still answers.
    task automatic fetch_clr(input logic [31:0] pc, input int d, input int post);
        settle();
        exp_mc_q.push_back(pc);
        mfill(pc);
        if_to_ic_valid = 1'b1;
        if_to_ic_pc    = pc;
        repeat (d) @(negedge clk_in);
        clr_in         = 1'b1;
        if_to_ic_valid = 1'b0;
        @(negedge clk_in);
        clr_in = 1'b0;
        repeat (post) @(negedge clk_in);
    endtask

    task automatic fetch_freeze(input logic [31:0] pc);
        int k;
        settle();
        mc_lat = 10;
        exp_mc_q.push_back(pc);
        exp_inst_q.push_back(mem_word(pc));
        mfill(pc);
        if_to_ic_valid = 1'b1;
        if_to_ic_pc    = pc;
        repeat (2) @(negedge clk_in);
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            check32("freeze_mc_ready", 32'(ic_to_mc_ready), 32'd1);
            check32("freeze_mc_pc", ic_to_mc_PC, pc);
            check32("freeze_if_ready", 32'(ic_to_if_ready), 32'd0);
        end
        rdy_in = 1'b1;
        k = 7;
        while (!ic_to_if_ready && k < 100) begin
            @(negedge clk_in);
            k++;
        end
        check32("freeze_latency", k, 12);
        just_served = ic_to_if_ready;
        if (!just_served) if_to_ic_valid = 1'b0;
    endtask

    task automatic fetch_reset(input logic [31:0] pc);
        settle();
        mc_mute = 1'b1;
        exp_mc_q.push_back(pc);
        if_to_ic_valid = 1'b1;
        if_to_ic_pc    = pc;
        repeat (3) @(negedge clk_in);
        #2 rst_in = 1'b0;
        #1;
        check32("rst_if_ready", 32'(ic_to_if_ready), 32'd0);
        check32("rst_if_inst", ic_to_if_inst, 32'd0);
        check32("rst_mc_ready", 32'(ic_to_mc_ready), 32'd0);
        check32("rst_mc_pc", ic_to_mc_PC, 32'd0);
        if_to_ic_valid = 1'b0;
        mclear();
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        mc_mute = 1'b0;
    endtask

    function automatic logic [31:0] rnd_pc();
        return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2) |
               32'($urandom_range(0, 3));
    endfunction

    initial begin
        int k;
        logic [31:0] pc;
        int r;
        mclear();
        mem_ovr[32'h10] = 32'h00A00093;
        mem_ovr[32'h20] = 32'h11111111;

        repeat (2) @(negedge clk_in);
        check32("reset_if_ready", 32'(ic_to_if_ready), 32'd0);
        check32("reset_if_inst", ic_to_if_inst, 32'd0);
        check32("reset_mc_ready", 32'(ic_to_mc_ready), 32'd0);
        check32("reset_mc_pc", ic_to_mc_PC, 32'd0);
        rst_in = 1'b1;
        @(negedge clk_in);

        // Cold miss, hit after fill, conflict on the same index.
        mc_lat = 6;
        fetch(32'h10, 1'b0, 1'b0);
        fetch(32'h10, 1'b0, 1'b0);
        mc_lat = 3;
        fetch(32'h110, 1'b0, 1'b0);
        fetch(32'h10, 1'b1, 1'b0);

        // Abort with a late controller answer, then the line hits.
        mc_lat = 6;
        fetch_clr(32'h20, 2, 12);
        fetch(32'h20, 1'b0, 1'b0);

        // Clear coinciding with the controller answer returns straight to IDLE.
        mc_lat = 4;
        fetch_clr(32'h30, 5, 1);
        fetch(32'h30, 1'b0, 1'b0);

        // Abort timeout with a silent controller, next miss queued behind it.
        settle();
        mc_mute = 1'b1;
        exp_mc_q.push_back(32'h240);
        if_to_ic_valid = 1'b1;
        if_to_ic_pc    = 32'h240;
        repeat (2) @(negedge clk_in);
        clr_in      = 1'b1;
        if_to_ic_pc = 32'h344;
        exp_mc_q.push_back(32'h344);
        exp_inst_q.push_back(mem_word(32'h344));
        mfill(32'h344);
        mc_lat = 3;
        @(negedge clk_in);
        clr_in  = 1'b0;
        mc_mute = 1'b0;
        k = 1;
        while (!ic_to_mc_ready && k < 40) begin
            @(negedge clk_in);
            k++;
        end
        check32("abort_timeout_cycles", k, ABORT + 2);
        k = 0;
        while (!ic_to_if_ready && k < 40) begin
            @(negedge clk_in);
            k++;
        end
        check32("after_timeout_latency", k, mc_lat + 1);
        if_to_ic_valid = 1'b0;
        @(negedge clk_in);

        fetch_freeze(32'h4000_0050);
        fetch(32'h4000_0050, 1'b0, 1'b0);

        fetch_reset(32'h5000_0010);
        mc_lat = 5;
        fetch(32'h10, 1'b0, 1'b0);

        for (int i = 0; i < 160; i++) begin
            pc = rnd_pc();
            r  = int'($urandom_range(0, 99));
            if (r < 12 && !mhit(pc)) begin
                mc_lat = int'($urandom_range(1, 6));
                fetch_clr(pc, int'($urandom_range(1, mc_lat + 1)), 12);
            end else begin
                mc_lat = int'($urandom_range(1, 8));
                fetch(pc, bit'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
            end
        end

        settle();
        if_to_ic_valid = 1'b0;
        repeat (20) @(negedge clk_in);
        check32("inst_queue_drained", exp_inst_q.size(), 0);
        check32("mc_queue_drained", exp_mc_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
